// File: rtl/seg_scan_driver_if.sv
// ============================================================================
// Module      : seg_scan_driver_if
// Description : Digit-code input bus and active-low display outputs of the
//               seven-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_scan_driver_if;
   logic [47:0] digits;
   logic [7:0]  an;
   logic [7:0]  seg;

   modport master (
      output digits,
      input  an,
      input  seg
   );

   modport slave (
      input  digits,
      output an,
      output seg
   );
endinterface

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module      : seg_scan_driver
// Description : Eight-digit common-anode seven-segment scan driver with
//               dead-time blanking, glyph decode and blink gating.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver #(
   parameter int SCAN_DIV    = 100000,
   parameter int DEAD_CYCLES = 16,
   parameter int BLINK_DIV   = 62
) (
   input  logic              clk,
   input  logic              rst_n,
   seg_scan_driver_if.slave  bus
);

   localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
   localparam int FRAME_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   localparam logic [SCAN_W-1:0]  c_SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [SCAN_W-1:0]  c_SCAN_DEAD  = SCAN_W'(DEAD_CYCLES);
   localparam logic [SCAN_W-1:0]  c_SCAN_ONE   = SCAN_W'(1);
   localparam logic [FRAME_W-1:0] c_FRAME_LAST = FRAME_W'(BLINK_DIV - 1);
   localparam logic [FRAME_W-1:0] c_FRAME_ONE  = FRAME_W'(1);

   logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
   logic [2:0]         idx_q, idx_d;
   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
   logic               blink_on_q, blink_on_d;
   logic [5:0]         cur_q, cur_d;
   logic [7:0]         an_q, an_d;
   logic [7:0]         seg_q, seg_d;

   logic [5:0]         w_led [8];

   for (genvar g = 0; g < 8; g++) begin : g_led
      assign w_led[g] = bus.digits[6*g +: 6];
   end

   // Active-high {g,f,e,d,c,b,a}; codes above 10 render blank.
   function automatic logic [6:0] f_glyph(input logic [3:0] code);
      logic [6:0] r;
      case (code)
         4'd0:    r = 7'b0111111;
         4'd1:    r = 7'b0000110;
         4'd2:    r = 7'b1011011;
         4'd3:    r = 7'b1001111;
         4'd4:    r = 7'b1100110;
         4'd5:    r = 7'b1101101;
         4'd6:    r = 7'b1111101;
         4'd7:    r = 7'b0000111;
         4'd8:    r = 7'b1111111;
         4'd9:    r = 7'b1101111;
         4'd10:   r = 7'b1000000;
         default: r = 7'b0000000;
      endcase
      return r;
   endfunction

   always_comb begin
      scan_cnt_d  = scan_cnt_q + c_SCAN_ONE;
      idx_d       = idx_q;
      frame_cnt_d = frame_cnt_q;
      blink_on_d  = blink_on_q;
      cur_d       = cur_q;

      if (scan_cnt_q == c_SCAN_LAST) begin
         scan_cnt_d = '0;
         idx_d      = idx_q + 3'd1;
         if (idx_q == 3'd7) begin
            if (frame_cnt_q == c_FRAME_LAST) begin
               frame_cnt_d = '0;
               blink_on_d  = ~blink_on_q;
            end else begin
               frame_cnt_d = frame_cnt_q + c_FRAME_ONE;
            end
         end
      end

      // Latch once per slot so a code change mid-slot never tears the glyph.
      if (scan_cnt_q == '0) begin
         cur_d = w_led[idx_q];
      end
   end

   always_comb begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
      if (scan_cnt_q >= c_SCAN_DEAD) begin
         an_d = ~(8'h01 << idx_q);
         if (!(cur_q[5] && !blink_on_q)) begin
            seg_d = ~{cur_q[4], f_glyph(cur_q[3:0])};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt_q  <= '0;
         idx_q       <= 3'd0;
         frame_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         cur_q       <= 6'h00;
         an_q        <= 8'hFF;
         seg_q       <= 8'hFF;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         idx_q       <= idx_d;
         frame_cnt_q <= frame_cnt_d;
         blink_on_q  <= blink_on_d;
         cur_q       <= cur_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;

endmodule

`default_nettype wire
